// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU top, the result stage and writeback.
// Signal names keep the stage's port naming; the stage uses the slave view.
interface alu_result_stage_if #(
  parameter int unsigned RD_W = 5
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [2:0]      instr_i;
  logic [63:0]     alu_out_i;
  logic [RD_W-1:0] rd_i;
  logic            wr_en_i;
  logic [1:0]      hilo_sel_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [RD_W-1:0] wb_rd_o;
  logic [31:0]     wb_data_o;
  logic            wb_en_o;
  logic [31:0]     hi_o;
  logic [31:0]     lo_o;
  logic [1:0]      count_o;

  modport master (
    output in_valid_i, instr_i, alu_out_i, rd_i, wr_en_i, hilo_sel_i, out_ready_i,
    input  in_ready_o, out_valid_o, wb_rd_o, wb_data_o, wb_en_o, hi_o, lo_o, count_o
  );

  modport slave (
    input  in_valid_i, instr_i, alu_out_i, rd_i, wr_en_i, hilo_sel_i, out_ready_i,
    output in_ready_o, out_valid_o, wb_rd_o, wb_data_o, wb_en_o, hi_o, lo_o, count_o
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: owns HI/LO, resolves MFHI/MFLO and buffers results in a 2-entry FIFO.
// One cycle push-to-head latency; in_ready drops at 2 entries, a pop frees a slot next cycle.
module alu_result_stage #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned RD_W   = 5,
  parameter logic [2:0]  MUL_OP = 3'd6,
  parameter logic [2:0]  DIV_OP = 3'd7
) (
  input logic               clk_i,
  input logic               rst_n_i,
  alu_result_stage_if.slave bus
);

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic            en;
  } entry_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t      mem_q [DEPTH];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic   in_ready;
  logic   out_valid;
  logic   push;
  logic   pop;
  logic   is_muldiv;
  entry_t new_entry;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != 2'd0);
  assign push      = bus.in_valid_i && in_ready;
  assign pop       = out_valid && bus.out_ready_i;
  assign is_muldiv = (bus.instr_i == MUL_OP) || (bus.instr_i == DIV_OP);

  // MFHI/MFLO read the registered HI/LO; every earlier MUL/DIV has already
  // committed at a previous edge because pushes are strictly one per cycle.
  always_comb begin
    new_entry.rd   = bus.rd_i;
    new_entry.data = bus.alu_out_i[31:0];
    new_entry.en   = bus.wr_en_i && (bus.rd_i != '0);
    if (is_muldiv) begin
      new_entry.en = 1'b0;
    end else if (bus.hilo_sel_i == 2'b01) begin
      new_entry.data = hi_q;
    end else if (bus.hilo_sel_i == 2'b10) begin
      new_entry.data = lo_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ~wr_ptr_q;
        if (is_muldiv) begin
          hi_q <= bus.alu_out_i[63:32];
          lo_q <= bus.alu_out_i[31:0];
        end
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head fields come straight from storage flops, so nothing from in_* reaches wb_*.
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.wb_rd_o     = mem_q[rd_ptr_q].rd;
  assign bus.wb_data_o   = mem_q[rd_ptr_q].data;
  assign bus.wb_en_o     = mem_q[rd_ptr_q].en;
  assign bus.hi_o        = hi_q;
  assign bus.lo_o        = lo_q;
  assign bus.count_o     = count_q;

endmodule
